// File: rtl/display_pkg.sv
// Shared types and helpers for the dual-source display switch.
// Holds the FSM encoding, RGB565 expansion and default sync polarity.
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  localparam logic VS_ACTIVE_DEF = 1'b0;

  function automatic logic [23:0] rgb565_to_888(input logic [15:0] d);
    return {d[15:11], 3'b000, d[10:5], 2'b00, d[4:0], 3'b000};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button synchroniser and debouncer.
// Emits a one-cycle pulse when the accepted level goes from released to pressed.
module key_debounce #(
  parameter int unsigned DEB_CNT = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic press_o
);

  localparam int unsigned CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CNT - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // A level is accepted only after DEB_CNT consecutive differing samples.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == LAST) begin
        level_d = sync2_q;
        press_d = level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/display_switch_ctrl.sv
// Two-input video source switch with frame-aligned switching
// and optional black frames after each switch.
module display_switch_ctrl
  import display_pkg::*;
#(
  parameter int unsigned DEB_CNT      = 500000,
  parameter int unsigned BLANK_FRAMES = 1,
  parameter logic        VS_ACTIVE    = VS_ACTIVE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_n,
  input  logic        in1_hs,
  input  logic        in1_vs,
  input  logic        in1_de,
  input  logic [15:0] in1_data,
  input  logic        in2_hs,
  input  logic        in2_vs,
  input  logic        in2_de,
  input  logic [15:0] in2_data,
  output logic        out_hs,
  output logic        out_vs,
  output logic        out_de,
  output logic [23:0] out_data,
  output logic        sel,
  output logic        busy
);

  localparam logic [2:0] BF3 = 3'(BLANK_FRAMES);

  logic        press;
  state_e      state_q, state_d;
  logic        sel_q, sel_d;
  logic        busy_q;
  logic        vs_hist_q, vs_hist_d;
  logic [1:0]  blank_cnt_q, blank_cnt_d;
  logic        cur_vs, alt_vs, frame_start, last_blank;
  logic        cur_hs, cur_de;
  logic [15:0] cur_pix;
  logic        hs_q, vs_q, de_q;
  logic [23:0] data_q;

  key_debounce #(
    .DEB_CNT(DEB_CNT)
  ) u_key (
    .clk    (clk),
    .rst    (rst),
    .key_n_i(key_n),
    .press_o(press)
  );

  always_comb begin
    cur_vs  = sel_q ? in2_vs : in1_vs;
    alt_vs  = sel_q ? in1_vs : in2_vs;
    cur_hs  = sel_q ? in2_hs : in1_hs;
    cur_de  = sel_q ? in2_de : in1_de;
    cur_pix = sel_q ? in2_data : in1_data;
  end

  assign frame_start = (cur_vs == VS_ACTIVE) && (vs_hist_q != VS_ACTIVE);
  assign last_blank  = ({1'b0, blank_cnt_q} + 3'd1) == BF3;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    blank_cnt_d = blank_cnt_q;
    vs_hist_d   = cur_vs;
    unique case (state_q)
      ST_IDLE: begin
        if (press) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (frame_start) begin
          sel_d       = ~sel_q;
          // Start edge detection on the new source from its current level.
          vs_hist_d   = alt_vs;
          blank_cnt_d = '0;
          state_d     = (BLANK_FRAMES == 0) ? ST_IDLE : ST_BLANK;
        end
      end
      ST_BLANK: begin
        if (frame_start) begin
          if (last_blank) state_d = ST_IDLE;
          else blank_cnt_d = blank_cnt_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= 1'b0;
      busy_q      <= 1'b0;
      vs_hist_q   <= ~VS_ACTIVE;
      blank_cnt_q <= '0;
      hs_q        <= 1'b0;
      vs_q        <= ~VS_ACTIVE;
      de_q        <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      busy_q      <= (state_d != ST_IDLE);
      vs_hist_q   <= vs_hist_d;
      blank_cnt_q <= blank_cnt_d;
      hs_q        <= cur_hs;
      vs_q        <= cur_vs;
      de_q        <= cur_de;
      data_q      <= (state_d == ST_BLANK) ? 24'h000000
                                           : rgb565_to_888(cur_pix);
    end
  end

  assign out_hs   = hs_q;
  assign out_vs   = vs_q;
  assign out_de   = de_q;
  assign out_data = data_q;
  assign sel      = sel_q;
  assign busy     = busy_q;

endmodule
